// File: rtl/serial_display_receiver.sv
// rtl/serial_display_receiver.sv - three-wire display stream receiver with frame length check
// Oversamples serial/sclk/latch, rebuilds frames MSB-first, flags short, long and stalled frames.
module serial_display_receiver #(
  parameter int FRAME_BITS = 48,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  sclk_in,
  input  logic                  latch_in,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_OVER  = CW'(FRAME_BITS + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_OVERRUN} state_e;

  // Bit order in the synchronizer vectors: {serial, sclk, latch}.
  logic [2:0]            meta_q, sync_q;
  logic [1:0]            hist_q;
  logic                  sclk_rise_q, latch_rise_q, data_q;
  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d, cnt_shift;
  logic [TW-1:0]         idle_q, idle_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d, frame_q, frame_d;
  logic                  valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  logic                  timeout;

  assign timeout = (state_q != S_IDLE) && !sclk_rise_q && (idle_q == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (latch_rise_q || timeout) begin
      state_d = S_IDLE;
    end else if (sclk_rise_q) begin
      case (state_q)
        S_IDLE:  state_d = S_SHIFT;
        S_SHIFT: if (count_q == CNT_FULL) state_d = S_OVERRUN;
        default: state_d = state_q;
      endcase
    end
  end

  // The shift is applied before the length check so a bit and latch in one cycle still count.
  always_comb begin
    shift_d   = shift_q;
    cnt_shift = count_q;
    if (sclk_rise_q) begin
      shift_d = {shift_q[FRAME_BITS-2:0], data_q};
      if (count_q != CNT_OVER) cnt_shift = count_q + CW'(1);
    end
    count_d = cnt_shift;
    frame_d = frame_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (latch_rise_q) begin
      count_d = '0;
      if (cnt_shift == CNT_FULL) begin
        frame_d = shift_d;
        valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (timeout) begin
      count_d = '0;
      err_d   = 1'b1;
    end
    idle_d = '0;
    if (!sclk_rise_q && !latch_rise_q && !timeout && state_q != S_IDLE) idle_d = idle_q + TW'(1);
    busy_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q       <= '0;
      sync_q       <= '0;
      hist_q       <= '0;
      sclk_rise_q  <= 1'b0;
      latch_rise_q <= 1'b0;
      data_q       <= 1'b0;
      count_q      <= '0;
      idle_q       <= '0;
      shift_q      <= '0;
      frame_q      <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      meta_q       <= {serial_in, sclk_in, latch_in};
      sync_q       <= meta_q;
      hist_q       <= sync_q[1:0];
      sclk_rise_q  <= sync_q[1] & ~hist_q[1];
      latch_rise_q <= sync_q[0] & ~hist_q[0];
      data_q       <= sync_q[2];
      count_q      <= count_d;
      idle_q       <= idle_d;
      shift_q      <= shift_d;
      frame_q      <= frame_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_serial_display_receiver.sv
// tb/tb_serial_display_receiver.sv - directed self-checking bench for serial_display_receiver
// Drives the three-wire stream at clk+1 and samples registered outputs at clk+1.
module tb_serial_display_receiver;
  localparam int FB = 48;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          rst, serial_in, sclk_in, latch_in;
  logic [FB-1:0] frame;
  logic          frame_valid, frame_err, busy;

  int vec = 0;
  int bad = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;

  always #4 clk = ~clk;

  serial_display_receiver #(.FRAME_BITS(FB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .sclk_in(sclk_in), .latch_in(latch_in),
    .frame(frame), .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
  );

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_err) fe_cnt++;
    if (frame_valid && frame_err) both_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    sclk_in = 1'b0;
    tick(4);
    sclk_in = 1'b1;
    tick(4);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  // Latch rise on the pin; the pulse must appear on exactly the 4th edge.
  task automatic do_latch(input string tag, input logic expect_valid);
    latch_in = 1'b1;
    tick(3);
    check({tag, " early"}, {frame_valid, frame_err}, 2'b00);
    tick(1);
    check({tag, " pulse"}, {frame_valid, frame_err}, expect_valid ? 2'b10 : 2'b01);
    check({tag, " busy"}, busy, 1'b0);
    latch_in = 1'b0;
    tick(1);
    check({tag, " one-shot"}, {frame_valid, frame_err}, 2'b00);
    tick(3);
  endtask

  initial begin
    int early;
    int fe0;
    int fv0;
    logic [63:0] v;

    rst = 1'b1;
    serial_in = 1'b0;
    sclk_in = 1'b0;
    latch_in = 1'b0;
    tick(3);
    check("reset frame", frame, 48'h0);
    check("reset flags", {frame_valid, frame_err, busy}, 3'b000);
    rst = 1'b0;
    tick(2);

    // Good frame, with busy rise timing on the first bit
    v = 64'h0000_0123_4567_89AB;
    serial_in = v[47];
    sclk_in = 1'b0;
    tick(4);
    sclk_in = 1'b1;
    tick(3);
    check("busy before 4clk", busy, 1'b0);
    tick(1);
    check("busy at 4clk", busy, 1'b1);
    tick(3);
    send_bits(v, 47);
    do_latch("good1", 1'b1);
    check("good1 frame", frame, 48'h0123_4567_89AB);
    check("good1 idle busy", busy, 1'b0);

    // Short and long frames
    send_bits(64'h0000_7FFF_0000_1234, 47);
    do_latch("short47", 1'b0);
    check("short47 frame held", frame, 48'h0123_4567_89AB);
    send_bits(64'h0001_2345_6789_ABCD, 49);
    do_latch("long49", 1'b0);
    check("long49 frame held", frame, 48'h0123_4567_89AB);
    check("no extra valid", fv_cnt, 1);

    // Timeout after 20 bits
    v = 64'h0000_0000_000A_BCDE;
    send_bits(v >> 1, 19);
    serial_in = v[0];
    sclk_in = 1'b0;
    tick(4);
    sclk_in = 1'b1;
    early = 0;
    for (int i = 0; i < TO + 3; i++) begin
      tick(1);
      if (frame_err || frame_valid) early++;
    end
    check("timeout no early pulse", early, 0);
    check("timeout busy held", busy, 1'b1);
    tick(1);
    check("timeout pulse", {frame_valid, frame_err}, 2'b01);
    check("timeout busy", busy, 1'b0);
    tick(1);
    check("timeout one-shot", frame_err, 1'b0);
    check("timeout frame held", frame, 48'h0123_4567_89AB);
    tick(2);
    send_bits(64'h0000_DEAD_BEEF_0042, 48);
    do_latch("after timeout", 1'b1);
    check("after timeout frame", frame, 48'hDEAD_BEEF_0042);

    // 48th sclk rise and latch rise on the same edge
    v = 64'h0000_5A5A_C3C3_0F0F;
    send_bits(v >> 1, 47);
    serial_in = v[0];
    sclk_in = 1'b0;
    tick(4);
    sclk_in = 1'b1;
    latch_in = 1'b1;
    tick(3);
    check("simul early", {frame_valid, frame_err}, 2'b00);
    tick(1);
    check("simul pulse", {frame_valid, frame_err}, 2'b10);
    check("simul frame", frame, 48'h5A5A_C3C3_0F0F);
    latch_in = 1'b0;
    tick(1);
    check("simul one-shot", frame_valid, 1'b0);
    tick(3);

    // Reset mid-frame
    send_bits(64'h0000_0000_2AAA_AAAA, 30);
    fe0 = fe_cnt;
    rst = 1'b1;
    sclk_in = 1'b0;
    tick(1);
    check("midreset frame", frame, 48'h0);
    check("midreset flags", {frame_valid, frame_err, busy}, 3'b000);
    tick(3);
    check("midreset hold flags", {frame_valid, frame_err, busy}, 3'b000);
    rst = 1'b0;
    tick(2);
    send_bits(64'h0000_FFFF_0000_A5A5, 48);
    do_latch("post reset", 1'b1);
    check("post reset frame", frame, 48'hFFFF_0000_A5A5);
    check("post reset no err", fe_cnt, fe0);

    // Back-to-back frames: sclk rise one clk after the latch rise
    fe0 = fe_cnt;
    fv0 = fv_cnt;
    send_bits(64'h1, 48);
    serial_in = 1'b1;
    sclk_in = 1'b0;
    tick(2);
    latch_in = 1'b1;
    tick(1);
    sclk_in = 1'b1;
    tick(3);
    check("b2b first pulse", {frame_valid, frame_err}, 2'b10);
    check("b2b first frame", frame, 48'h1);
    tick(1);
    check("b2b next busy", busy, 1'b1);
    check("b2b first one-shot", frame_valid, 1'b0);
    latch_in = 1'b0;
    tick(3);
    send_bits(64'h0, 47);
    do_latch("b2b second", 1'b1);
    check("b2b second frame", frame, 48'h8000_0000_0000);
    check("b2b valid count", fv_cnt - fv0, 2);
    check("b2b no err", fe_cnt - fe0, 0);

    check("valid/err exclusive", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/serial_display_receiver.md
# serial_display_receiver

Receives the three-wire display stream (serial data, shift clock, latch) produced by the display output stage and rebuilds the parallel frame inside the system clock domain. It sits directly downstream of the output shifter. It is used as the on-chip loopback/readback checker and as the front end of the cascaded display board. The block oversamples the asynchronous stream, checks frame length, and publishes each complete frame with a one-cycle strobe.

## Interface
Parameters:
- FRAME_BITS, 48, bits per frame (6 digits × 8 segment bits); minimum 2.
- TIMEOUT, 1024, system clocks without a shift-clock edge before a partial frame is discarded; minimum 4.

Ports:
- clk  input  1  system clock; everything is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- serial_in  input  1  stream data; asynchronous to clk.
- sclk_in  input  1  stream shift clock; data is valid at its rising edge; asynchronous.
- latch_in  input  1  stream latch; a rising edge ends the frame; asynchronous.
- frame  output  FRAME_BITS  last good frame; the first received bit is in the MSB.
- frame_valid  output  1  one-cycle pulse when frame updates.
- frame_err  output  1  one-cycle pulse on a bad or aborted frame.
- busy  output  1  high while a partial frame is held (bit count ≠ 0).

## Operation
- Input conditioning:
  - Each input passes through a 2-flop synchronizer, followed by one history flop.
  - sclk_rise = sync & ~hist; the same rule gives latch_rise.
  - Data is sampled from the synchronized serial_in at the same pipeline stage as sclk_rise, so skew between data and clock is ≤1 clk.
- On sclk_rise: shift_reg <= {shift_reg[FRAME_BITS-2:0], serial_sync}. The bit count increments and saturates at FRAME_BITS+1.
- State machine:
  - IDLE (count=0).
  - SHIFT (1 ≤ count ≤ FRAME_BITS).
  - OVERRUN (count = FRAME_BITS+1).
- Transitions:
  - IDLE → SHIFT on sclk_rise.
  - SHIFT → OVERRUN when a bit arrives at count=FRAME_BITS.
  - Any state → IDLE on latch_rise or timeout.
- latch_rise handling:
  - If count == FRAME_BITS: frame <= shift_reg and frame_valid pulses.
  - Otherwise, including count=0 and OVERRUN: frame_err pulses and frame holds its value.
  - In every case count <= 0.
- Timeout:
  - The idle counter clears on every sclk_rise and counts while state ≠ IDLE.
  - On reaching TIMEOUT: frame_err pulses, count <= 0, state → IDLE, frame unchanged.
- Simultaneous sclk_rise and latch_rise in one cycle:
  - The shift is applied first.
  - The length check uses count+1 and the post-shift register.
- Timeout and latch_rise in the same cycle: latch_rise takes precedence; there is exactly one pulse.
- frame_valid and frame_err are never high together.
- Reset values:
  - frame, frame_valid, frame_err, busy, shift_reg, all counters, synchronizer and history flops: 0.
  - State: IDLE.
  - Reset mid-frame discards the partial frame with no error pulse.

## Timing
- Input pin edge to internal rise detect: 3 clk (2 sync + 1 history).
- latch_in pin rise to frame/frame_valid (or frame_err): 4 clk; outputs are registered.
- busy rises 4 clk after the first sclk_in rise. It falls in the same cycle as the frame_valid/frame_err pulse.
- Input constraints:
  - sclk_in and latch_in high and low times ≥ 2 clk each.
  - serial_in stable ≥ 2 clk before and ≥ 1 clk after each sclk_in rise.
  - Violations are out of spec; there is no detection beyond length checking.
- Throughput: back-to-back frames with zero gap after the latch are accepted. A sclk_rise in the cycle after latch_rise is bit 1 of the next frame.

## Test plan
- Reset, then 48 bits of 48'h0123_4567_89AB MSB-first, then a latch rise (clk period 8, sclk period 64) -> frame=48'h0123_4567_89AB and one frame_valid pulse 4 clk after the latch; busy=0 afterwards.
- 47 bits then latch -> frame_err pulse; frame keeps its previous value; frame_valid stays 0. Repeat with 49 bits -> frame_err.
- 20 bits then no activity -> frame_err exactly TIMEOUT clk after the last detected sclk_rise; busy=0. A subsequent good 48-bit frame is received correctly.
- The 48th sclk_in rise and latch_in rise on the same clk edge -> frame_valid. The frame includes the 48th bit.
- Assert rst after 30 bits, release, send a good frame 48'hFFFF_0000_A5A5 -> no frame_err; frame=48'hFFFF_0000_A5A5. All outputs are 0 during reset.
- Two good frames with zero gap (48'h1, then 48'h8000_0000_0000) -> two frame_valid pulses with the matching frame values; no frame_err.
